// File: rtl/mem_wb_pipe_stage_pkg.sv
// mips_pipe_pkg: definitions shared by the MEM/WB pipeline stage.
//   DEF_DATA_W / DEF_REG_ADDR_W / DEF_CNT_W : default widths
//   occ_state_t    : stage occupancy state
//   mem_wb_entry_t : one MEM/WB entry at the default widths
package mips_pipe_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_CNT_W      = 16;

  // EMPTY/ONE/TWO are used with the skid buffer; EMPTY/FULL without it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_FULL  = 2'd3
  } occ_state_t;

  typedef struct packed {
    logic                      RegWrite;
    logic                      MemtoReg;
    logic [DEF_DATA_W-1:0]     readData;
    logic [DEF_DATA_W-1:0]     ALUresult;
    logic [DEF_REG_ADDR_W-1:0] writeReg;
  } mem_wb_entry_t;

endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// mem_wb_pipe_stage_if: MEM-side input bus, WB-side output bus and flush of
// the MEM/WB stage.
//   slave  : stage view (i_* in, o_* out)
//   master : driver/sink view (i_* out, o_* in)
interface mem_wb_pipe_stage_if
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
);

  logic                  i_flush;
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_RegWrite;
  logic                  i_MemtoReg;
  logic [DATA_W-1:0]     i_ALUresult;
  logic [DATA_W-1:0]     i_readData;
  logic [REG_ADDR_W-1:0] i_writeReg;

  logic                  o_valid;
  logic                  i_ready;
  logic                  o_RegWrite;
  logic                  o_MemtoReg;
  logic [DATA_W-1:0]     o_readData;
  logic [DATA_W-1:0]     o_ALUresult;
  logic [REG_ADDR_W-1:0] o_writeReg;
  logic [DATA_W-1:0]     o_wb_data;
  logic                  o_fwd_valid;
  logic [CNT_W-1:0]      o_bubble_cnt;

  modport slave (
    input  i_flush, i_valid, i_RegWrite, i_MemtoReg, i_ALUresult,
           i_readData, i_writeReg, i_ready,
    output o_ready, o_valid, o_RegWrite, o_MemtoReg, o_readData,
           o_ALUresult, o_writeReg, o_wb_data, o_fwd_valid, o_bubble_cnt
  );

  modport master (
    output i_flush, i_valid, i_RegWrite, i_MemtoReg, i_ALUresult,
           i_readData, i_writeReg, i_ready,
    input  o_ready, o_valid, o_RegWrite, o_MemtoReg, o_readData,
           o_ALUresult, o_writeReg, o_wb_data, o_fwd_valid, o_bubble_cnt
  );

endinterface

// File: rtl/mem_wb_pipe_stage_sat_counter.sv
// sat_counter: up-counter that stops at all-ones instead of wrapping.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low clear
//   i_en    : count enable
//   o_cnt   : current count
module sat_counter
  import mips_pipe_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: MEM/WB pipeline register with valid/ready flow control,
// flush, writeback-data select, forwarding qualifier and bubble counter.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   io_mw   : stage bus (slave modport)
//     i_flush                 drop every held entry and the same-cycle input
//     i_valid / o_ready       MEM-side handshake
//     i_RegWrite .. i_writeReg MEM-side entry fields
//     o_valid / i_ready       WB-side handshake
//     o_RegWrite .. o_writeReg head entry fields (o_RegWrite gated by o_valid)
//     o_wb_data               head MemtoReg ? readData : ALUresult
//     o_fwd_valid             head valid, writing, destination not r0
//     o_bubble_cnt            saturating count of cycles without a head
// Build option MEM_WB_SKID_EN: 2-entry skid buffer with registered o_ready.
// Without it: single entry, o_ready = !o_valid | i_ready.
module mem_wb_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  mem_wb_pipe_stage_if.slave  io_mw
);

  // Same layout as mem_wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [DATA_W-1:0]     readData;
    logic [DATA_W-1:0]     ALUresult;
    logic [REG_ADDR_W-1:0] writeReg;
  } entry_t;

  occ_state_t r_state;
  logic       r_valid;
  entry_t     r_head;

  entry_t     w_in;
  logic       w_ready;
  logic       w_accept;
  logic       w_pop;
  logic       w_bubble_en;

  assign w_in = '{
    RegWrite:  io_mw.i_RegWrite,
    MemtoReg:  io_mw.i_MemtoReg,
    readData:  io_mw.i_readData,
    ALUresult: io_mw.i_ALUresult,
    writeReg:  io_mw.i_writeReg
  };

  assign w_accept = io_mw.i_valid & w_ready;
  assign w_pop    = r_valid & io_mw.i_ready;

`ifdef MEM_WB_SKID_EN

  entry_t r_skid;
  logic   r_ready;

  // o_ready comes straight from a flop; it is low only in TWO, so i_ready
  // never reaches o_ready combinationally.
  assign w_ready = r_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (io_mw.i_flush) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_head  <= w_in;
            r_state <= ST_ONE;
            r_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_head <= w_in;
          end else if (w_accept) begin
            r_skid  <= w_in;
            r_state <= ST_TWO;
            r_ready <= 1'b0;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_head  <= r_skid;
            r_state <= ST_ONE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`else

  assign w_ready = ~r_valid | io_mw.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (io_mw.i_flush) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_head  <= w_in;
            r_state <= ST_FULL;
            r_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          // An accept while FULL implies a same-cycle pop: replace the head.
          if (w_accept) begin
            r_head <= w_in;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`endif

  assign io_mw.o_ready     = w_ready;
  assign io_mw.o_valid     = r_valid;
  assign io_mw.o_RegWrite  = r_valid & r_head.RegWrite;
  assign io_mw.o_MemtoReg  = r_head.MemtoReg;
  assign io_mw.o_readData  = r_head.readData;
  assign io_mw.o_ALUresult = r_head.ALUresult;
  assign io_mw.o_writeReg  = r_head.writeReg;
  assign io_mw.o_wb_data   = r_head.MemtoReg ? r_head.readData : r_head.ALUresult;
  // r0 writes still go to the register file; only forwarding ignores them.
  assign io_mw.o_fwd_valid = r_valid & r_head.RegWrite & (r_head.writeReg != '0);

  assign w_bubble_en = ~r_valid;

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_bubble_en),
    .o_cnt   (io_mw.o_bubble_cnt)
  );

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
module tb_mem_wb_pipe_stage;
  import mips_pipe_pkg::*;

`ifdef MEM_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_pipe_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) mw ();
  mem_wb_pipe_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4))  mw4 ();

  mem_wb_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_mw   (mw.slave)
  );

  mem_wb_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_mw   (mw4.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the held entries in arrival order plus bubble counts.
  mem_wb_entry_t q[$];
  int unsigned   bub  = 0;
  int unsigned   bub4 = 0;
  bit            cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    if (SKID) return (q.size() < 2);
    return (q.size() == 0) || (mw.i_ready == 1'b1);
  endfunction

  task automatic model_edge();
    bit            acc;
    bit            pop;
    mem_wb_entry_t e;
    acc = mw.i_valid && exp_ready();
    pop = (q.size() != 0) && mw.i_ready;
    if (q.size() == 0) begin
      if (bub < 65535) bub++;
    end
    if (bub4 < 15) bub4++;
    if (mw.i_flush) begin
      q.delete();
    end else begin
      if (pop) q.delete(0);
      if (acc) begin
        e.RegWrite  = mw.i_RegWrite;
        e.MemtoReg  = mw.i_MemtoReg;
        e.readData  = mw.i_readData;
        e.ALUresult = mw.i_ALUresult;
        e.writeReg  = mw.i_writeReg;
        q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q.delete();
    bub  = 0;
    bub4 = 0;
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
    mw.i_valid     = v;
    mw.i_RegWrite  = rw;
    mw.i_MemtoReg  = m2r;
    mw.i_readData  = rd;
    mw.i_ALUresult = alu;
    mw.i_writeReg  = wr;
  endtask

  task automatic compare_all();
    bit            v;
    mem_wb_entry_t f;
    v = (q.size() != 0);
    f = '0;
    if (v) f = q[0];
    chk("o_valid",      64'(mw.o_valid),      64'(v));
    chk("o_ready",      64'(mw.o_ready),      64'(exp_ready()));
    chk("o_RegWrite",   64'(mw.o_RegWrite),   64'(v && f.RegWrite));
    chk("o_fwd_valid",  64'(mw.o_fwd_valid),  64'(v && f.RegWrite && (f.writeReg != 5'd0)));
    chk("o_bubble_cnt", 64'(mw.o_bubble_cnt), 64'(bub));
    chk("cnt4_bubble",  64'(mw4.o_bubble_cnt), 64'(bub4));
    if (v) begin
      chk("o_MemtoReg",  64'(mw.o_MemtoReg),  64'(f.MemtoReg));
      chk("o_readData",  64'(mw.o_readData),  64'(f.readData));
      chk("o_ALUresult", 64'(mw.o_ALUresult), 64'(f.ALUresult));
      chk("o_writeReg",  64'(mw.o_writeReg),  64'(f.writeReg));
      chk("o_wb_data",   64'(mw.o_wb_data),   64'(f.MemtoReg ? f.readData : f.ALUresult));
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) compare_all();
  end

  initial begin
    mw.i_flush = 1'b0;
    mw.i_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    mw4.i_flush = 1'b0;
    mw4.i_valid = 1'b0;
    mw4.i_ready = 1'b1;
    mw4.i_RegWrite = 1'b0;
    mw4.i_MemtoReg = 1'b0;
    mw4.i_readData = '0;
    mw4.i_ALUresult = '0;
    mw4.i_writeReg = '0;
    apply_reset();
    cmp_en = 1'b1;

    // Reset values
    repeat (2) step();
    chk("rst_o_valid",     64'(mw.o_valid),      64'd0);
    chk("rst_o_RegWrite",  64'(mw.o_RegWrite),   64'd0);
    chk("rst_o_MemtoReg",  64'(mw.o_MemtoReg),   64'd0);
    chk("rst_o_readData",  64'(mw.o_readData),   64'd0);
    chk("rst_o_ALUresult", 64'(mw.o_ALUresult),  64'd0);
    chk("rst_o_writeReg",  64'(mw.o_writeReg),   64'd0);
    chk("rst_o_wb_data",   64'(mw.o_wb_data),    64'd0);
    chk("rst_o_fwd_valid", 64'(mw.o_fwd_valid),  64'd0);
    chk("rst_o_bubble",    64'(mw.o_bubble_cnt), 64'd0);
    chk("rst_o_ready",     64'(mw.o_ready),      64'd1);
    rst_n = 1'b1;

    // Idle counting and saturation of the 4-bit counter
    repeat (10) step();
    chk("idle10_bubble", 64'(mw.o_bubble_cnt), 64'd10);
    repeat (10) step();
    chk("idle20_bubble",   64'(mw.o_bubble_cnt),  64'd20);
    chk("idle20_cnt4_sat", 64'(mw4.o_bubble_cnt), 64'd15);

    // Memory writeback to r8
    mw.i_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd8);
    step();
    chk("ld_o_valid",    64'(mw.o_valid),     64'd1);
    chk("ld_o_wb_data",  64'(mw.o_wb_data),   64'hDEADBEEF);
    chk("ld_o_fwd",      64'(mw.o_fwd_valid), 64'd1);

    // ALU writeback to r0: RegWrite passes, forwarding masked
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h12345678, 5'd0);
    step();
    chk("r0_o_wb_data",  64'(mw.o_wb_data),   64'h12345678);
    chk("r0_o_RegWrite", 64'(mw.o_RegWrite),  64'd1);
    chk("r0_o_fwd",      64'(mw.o_fwd_valid), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("drain_o_valid",    64'(mw.o_valid),    64'd0);
    chk("drain_o_RegWrite", 64'(mw.o_RegWrite), 64'd0);

    // Backpressure: A, B, C with downstream stalled
    mw.i_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'hAAAA0001, 32'h0, 5'd1);
    step();
    chk("bp_A_valid",    64'(mw.o_valid),    64'd1);
    chk("bp_A_readData", 64'(mw.o_readData), 64'hAAAA0001);
    chk("bp_A_ready",    64'(mw.o_ready),    SKID ? 64'd1 : 64'd0);
    drive(1'b1, 1'b1, 1'b1, 32'hBBBB0002, 32'h0, 5'd2);
    step();
    chk("bp_B_ready",    64'(mw.o_ready),    64'd0);
    chk("bp_B_readData", 64'(mw.o_readData), 64'hAAAA0001);
    drive(1'b1, 1'b1, 1'b1, 32'hCCCC0003, 32'h0, 5'd3);
    step();
    chk("bp_C_ready",    64'(mw.o_ready),    64'd0);
    chk("bp_C_readData", 64'(mw.o_readData), 64'hAAAA0001);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    mw.i_ready = 1'b1;
    step();
    chk("pop1_valid",    64'(mw.o_valid),    SKID ? 64'd1 : 64'd0);
    chk("pop1_readData", 64'(mw.o_readData), SKID ? 64'hBBBB0002 : 64'hAAAA0001);
    chk("pop1_ready",    64'(mw.o_ready),    64'd1);
    step();
    chk("pop2_valid",    64'(mw.o_valid),    64'd0);

    // Flush with entries held and a same-cycle input
    mw.i_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h11111111, 5'd4);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h22222222, 5'd5);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h33333333, 5'd6);
    mw.i_flush = 1'b1;
    step();
    mw.i_flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("fl_o_valid",    64'(mw.o_valid),     64'd0);
    chk("fl_o_RegWrite", 64'(mw.o_RegWrite),  64'd0);
    chk("fl_o_fwd",      64'(mw.o_fwd_valid), 64'd0);
    step();
    chk("fl_after_valid", 64'(mw.o_valid), 64'd0);
    chk("fl_after_ready", 64'(mw.o_ready), 64'd1);

    // Random traffic with one reset while stalled
    for (int unsigned cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) begin
        mw.i_flush = 1'b0;
        mw.i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          drive(1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'd7);
          step();
        end
        apply_reset();
        #1;
        chk("midrst_o_valid",  64'(mw.o_valid),      64'd0);
        chk("midrst_o_bubble", 64'(mw.o_bubble_cnt), 64'd0);
        step();
        step();
        rst_n = 1'b1;
      end
      mw.i_ready = ($urandom_range(0, 9) < 6);
      mw.i_flush = ($urandom_range(0, 63) == 0);
      drive(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)));
      step();
    end

    mw.i_flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    mw.i_ready = 1'b1;
    repeat (4) step();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
